// File: rtl/mips_wb_pkg.sv
// Shared types and constants for the MIPS writeback queue.
//   wb_entry_t : one pending register write {reg_idx, data} at the default widths
//   REG_ZERO   : hard-wired zero register index; writes to it are discarded
package mips_wb_pkg;

  localparam int unsigned WB_ADDR_W = 5;
  localparam int unsigned WB_DATA_W = 32;
  localparam int unsigned REG_ZERO  = 0;

  typedef struct packed {
    logic [WB_ADDR_W-1:0] reg_idx;
    logic [WB_DATA_W-1:0] data;
  } wb_entry_t;

endpackage

// File: rtl/mips_wb_fifo.sv
// Dual-push / single-pop circular buffer.
//   clk, reset      : clock, synchronous active-low reset (clears pointers and count)
//   push_a, data_a  : older push of this cycle
//   push_b, data_b  : younger push of this cycle (lands after data_a when both push)
//   head            : oldest entry (valid when count != 0)
//   count           : occupied entries; head pops on every edge with count != 0
//   entries, valid  : all slots rotated so index 0 is the oldest; valid marks occupied slots
module mips_wb_fifo #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned W     = 37
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          push_a,
  input  logic [W-1:0]                  data_a,
  input  logic                          push_b,
  input  logic [W-1:0]                  data_b,
  output logic [W-1:0]                  head,
  output logic [$clog2(DEPTH):0]        count,
  output logic [DEPTH-1:0][W-1:0]       entries,
  output logic [DEPTH-1:0]              valid
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;

  logic [W-1:0]  mem [DEPTH];
  logic [PW-1:0] rd_ptr;
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] wr_ptr_b;
  logic          pop;

  assign pop      = (count != '0);
  assign wr_ptr_b = push_a ? wr_ptr + PW'(1) : wr_ptr;

  always_ff @(posedge clk) begin
    if (!reset) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      rd_ptr <= rd_ptr + PW'(pop);
      wr_ptr <= wr_ptr + PW'(push_a) + PW'(push_b);
      count  <= count + CW'(push_a) + CW'(push_b) - CW'(pop);
    end
  end

  // Storage needs no reset: stale slots are masked by count.
  always_ff @(posedge clk) begin
    if (push_a) mem[wr_ptr]   <= data_a;
    if (push_b) mem[wr_ptr_b] <= data_b;
  end

  always_comb begin
    entries = '0;
    valid   = '0;
    for (int unsigned k = 0; k < DEPTH; k++) begin
      entries[k] = mem[rd_ptr + PW'(k)];
      valid[k]   = (CW'(k) < count);
    end
  end

  assign head = entries[0];

endmodule

// File: rtl/mips_writeback_queue.sv
// Writeback queue feeding the single register-file write port.
// ALU and load results are queued in order (ALU before load on the same edge)
// and drained one per cycle; pending values can be looked up by decode.
// Optional feature macro: WB_BYPASS_EN (pending-value lookup; ports tie to 0 when undefined).
//   clk, reset                      : clock, synchronous active-low reset
//   alu_valid/ready/reg/data        : ALU result handshake
//   mem_valid/ready/reg/data        : load result handshake
//   write_enable/reg/data           : register-file write port (head of queue)
//   look_reg_n/look_hit_n/look_data_n : pending-value lookup, youngest match wins
//   count                           : occupied entries
module mips_writeback_queue
  import mips_wb_pkg::*;
#(
  parameter int unsigned DEPTH  = 4,
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ADDR_W = 5
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     alu_valid,
  output logic                     alu_ready,
  input  logic [ADDR_W-1:0]        alu_reg,
  input  logic [DATA_W-1:0]        alu_data,
  input  logic                     mem_valid,
  output logic                     mem_ready,
  input  logic [ADDR_W-1:0]        mem_reg,
  input  logic [DATA_W-1:0]        mem_data,
  output logic                     write_enable,
  output logic [ADDR_W-1:0]        write_reg,
  output logic [DATA_W-1:0]        write_data,
  input  logic [ADDR_W-1:0]        look_reg_1,
  output logic                     look_hit_1,
  output logic [DATA_W-1:0]        look_data_1,
  input  logic [ADDR_W-1:0]        look_reg_2,
  output logic                     look_hit_2,
  output logic [DATA_W-1:0]        look_data_2,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int unsigned CW = $clog2(DEPTH) + 1;
  localparam int unsigned EW = ADDR_W + DATA_W;

  logic                    alu_push;
  logic                    mem_push;
  logic                    push_a;
  logic                    push_b;
  logic [EW-1:0]           data_a;
  logic [EW-1:0]           data_b;
  logic [EW-1:0]           head;
  logic [DEPTH-1:0][EW-1:0] entries;
  logic [DEPTH-1:0]        valid;

  // Ready looks at the current count only; the same-cycle pop is not credited.
  assign alu_ready = (count < CW'(DEPTH));
  assign mem_ready = (count <= CW'(DEPTH - 2)) || ((count < CW'(DEPTH)) && !alu_valid);

  // Register-0 writes complete the handshake but never enter the queue.
  assign alu_push = alu_valid && alu_ready && (alu_reg != ADDR_W'(REG_ZERO));
  assign mem_push = mem_valid && mem_ready && (mem_reg != ADDR_W'(REG_ZERO));

  // Compact the two sources so the older accepted result always uses slot a.
  assign push_a = alu_push || mem_push;
  assign push_b = alu_push && mem_push;
  assign data_a = alu_push ? {alu_reg, alu_data} : {mem_reg, mem_data};
  assign data_b = {mem_reg, mem_data};

  mips_wb_fifo #(
    .DEPTH (DEPTH),
    .W     (EW)
  ) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .push_a  (push_a),
    .data_a  (data_a),
    .push_b  (push_b),
    .data_b  (data_b),
    .head    (head),
    .count   (count),
    .entries (entries),
    .valid   (valid)
  );

  assign write_enable = (count != '0);
  assign write_reg    = write_enable ? head[EW-1:DATA_W] : '0;
  assign write_data   = write_enable ? head[DATA_W-1:0]  : '0;

`ifdef WB_BYPASS_EN
  // Scan oldest to youngest so the last match (youngest) wins.
  always_comb begin
    look_hit_1  = 1'b0;
    look_data_1 = '0;
    look_hit_2  = 1'b0;
    look_data_2 = '0;
    for (int unsigned k = 0; k < DEPTH; k++) begin
      if (valid[k] && look_reg_1 != ADDR_W'(REG_ZERO) && entries[k][EW-1:DATA_W] == look_reg_1) begin
        look_hit_1  = 1'b1;
        look_data_1 = entries[k][DATA_W-1:0];
      end
      if (valid[k] && look_reg_2 != ADDR_W'(REG_ZERO) && entries[k][EW-1:DATA_W] == look_reg_2) begin
        look_hit_2  = 1'b1;
        look_data_2 = entries[k][DATA_W-1:0];
      end
    end
  end
`else
  logic unused_lookup;
  assign unused_lookup = ^{look_reg_1, look_reg_2, entries, valid};
  assign look_hit_1  = 1'b0;
  assign look_data_1 = '0;
  assign look_hit_2  = 1'b0;
  assign look_data_2 = '0;
`endif

endmodule

// File: tb/tb_mips_writeback_queue.sv
// Scoreboard bench for mips_writeback_queue (default parameters).
module tb_mips_writeback_queue;
  import mips_wb_pkg::*;

  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic        alu_valid, alu_ready, mem_valid, mem_ready;
  logic [4:0]  alu_reg, mem_reg, write_reg, look_reg_1, look_reg_2;
  logic [31:0] alu_data, mem_data, write_data, look_data_1, look_data_2;
  logic        write_enable, look_hit_1, look_hit_2;
  logic [2:0]  count;

  always #5 clk = ~clk;

  mips_writeback_queue #(.DEPTH(4), .DATA_W(32), .ADDR_W(5)) dut (
    .clk(clk), .reset(reset),
    .alu_valid(alu_valid), .alu_ready(alu_ready), .alu_reg(alu_reg), .alu_data(alu_data),
    .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_reg(mem_reg), .mem_data(mem_data),
    .write_enable(write_enable), .write_reg(write_reg), .write_data(write_data),
    .look_reg_1(look_reg_1), .look_hit_1(look_hit_1), .look_data_1(look_data_1),
    .look_reg_2(look_reg_2), .look_hit_2(look_hit_2), .look_data_2(look_data_2),
    .count(count)
  );

  wb_entry_t sb[$];
  int tests = 0;
  int failed = 0;
  bit alu_acc, mem_acc;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    tests++;
    if (got !== exp) begin
      failed++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic void model_lookup(input logic [4:0] r, output logic hit, output logic [31:0] d);
    hit = 1'b0;
    d   = '0;
`ifdef WB_BYPASS_EN
    foreach (sb[i]) begin
      if (r != 5'd0 && sb[i].reg_idx == r) begin
        hit = 1'b1;
        d   = sb[i].data;
      end
    end
`endif
  endfunction

  // Check outputs mid-cycle, then update the model for the coming edge.
  task automatic step();
    logic e_alu, e_mem, h;
    logic [31:0] d;
    wb_entry_t e;
    @(negedge clk);
    e_alu = (sb.size() < DEPTH);
    e_mem = (sb.size() <= DEPTH - 2) || (sb.size() < DEPTH && !alu_valid);
    check_eq("count", 64'(count), 64'(sb.size()));
    check_eq("alu_ready", 64'(alu_ready), 64'(e_alu));
    check_eq("mem_ready", 64'(mem_ready), 64'(e_mem));
    check_eq("write_enable", 64'(write_enable), 64'(sb.size() != 0));
    check_eq("write_reg", 64'(write_reg), sb.size() != 0 ? 64'(sb[0].reg_idx) : 64'd0);
    check_eq("write_data", 64'(write_data), sb.size() != 0 ? 64'(sb[0].data) : 64'd0);
    model_lookup(look_reg_1, h, d);
    check_eq("look_hit_1", 64'(look_hit_1), 64'(h));
    check_eq("look_data_1", 64'(look_data_1), 64'(d));
    model_lookup(look_reg_2, h, d);
    check_eq("look_hit_2", 64'(look_hit_2), 64'(h));
    check_eq("look_data_2", 64'(look_data_2), 64'(d));
    alu_acc = alu_valid && e_alu;
    mem_acc = mem_valid && e_mem;
    if (sb.size() != 0) void'(sb.pop_front());
    if (!reset) begin
      sb.delete();
    end else begin
      if (alu_acc && alu_reg != 5'd0) begin e.reg_idx = alu_reg; e.data = alu_data; sb.push_back(e); end
      if (mem_acc && mem_reg != 5'd0) begin e.reg_idx = mem_reg; e.data = mem_data; sb.push_back(e); end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic av, input logic [4:0] ar, input logic [31:0] ad,
                       input logic mv, input logic [4:0] mr, input logic [31:0] md);
    alu_valid = av; alu_reg = ar; alu_data = ad;
    mem_valid = mv; mem_reg = mr; mem_data = md;
  endtask

  task automatic idle(input int n);
    drive(0, 0, 0, 0, 0, 0);
    for (int i = 0; i < n; i++) step();
  endtask

  initial begin
    reset = 1'b0;
    drive(0, 0, 0, 0, 0, 0);
    look_reg_1 = 5'd8;
    look_reg_2 = 5'd16;
    repeat (2) @(posedge clk);
    #1;
    step();                       // reset state observed with reset still low
    reset = 1'b1;

    // single ALU result
    drive(1, 5'd16, 32'd1234567, 0, 0, 0); step();
    idle(2);

    // both sources on one edge: ALU first
    drive(1, 5'd20, 32'd7654321, 1, 5'd16, 32'd42); step();
    idle(3);

    // saturate with both valid; mem held until accepted
    for (int i = 0; i < 10; i++) begin
      if (i == 0 || mem_acc) begin mem_reg = 5'(1 + (i % 7)); mem_data = 32'h1000 + 32'(i); end
      alu_valid = 1'b1; alu_reg = 5'(8 + (i % 5)); alu_data = 32'h2000 + 32'(i);
      mem_valid = 1'b1;
      step();
    end
    idle(5);

    // reg 0 is accepted but dropped
    drive(1, 5'd0, 32'd99, 0, 0, 0); step();
    idle(2);

    // youngest pending value wins
    look_reg_1 = 5'd8;
    drive(1, 5'd8, 32'd5, 1, 5'd8, 32'd9); step();
    idle(3);

    // reset with three entries queued
    drive(1, 5'd3, 32'd33, 1, 5'd4, 32'd44); step();
    drive(1, 5'd5, 32'd55, 1, 5'd6, 32'd66); step();
    drive(0, 0, 0, 0, 0, 0);
    reset = 1'b0; step();
    reset = 1'b1;
    idle(4);

    // random traffic with holds, lookups and occasional reset
    alu_acc = 1'b1; mem_acc = 1'b1;
    for (int i = 0; i < 300; i++) begin
      alu_valid = 1'($urandom_range(0, 1));
      alu_reg   = 5'($urandom_range(0, 7));
      alu_data  = $urandom;
      if (mem_acc || !mem_valid) begin
        mem_valid = 1'($urandom_range(0, 1));
        mem_reg   = 5'($urandom_range(0, 7));
        mem_data  = $urandom;
      end
      look_reg_1 = 5'($urandom_range(0, 7));
      look_reg_2 = 5'($urandom_range(0, 7));
      reset = ($urandom_range(0, 49) != 0);
      step();
    end
    reset = 1'b1;
    idle(6);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
